fifo_stream_reader: RTL and testbench
=====================================

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of FIFO read data and output stream data.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port drain_en  input  1  high permits new FIFO reads.
REQ-005 SHALL have port fifo_empty  input  1  empty flag from the synchronous FIFO read side.
REQ-006 SHALL have port fifo_data  input  DATA_WIDTH  FIFO read data, valid the cycle after an accepted read.
REQ-007 SHALL have port fifo_read_en  output  1  FIFO read strobe; each cycle high with fifo_empty low pops one entry.
REQ-008 SHALL have port out_data  output  DATA_WIDTH  stream data.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid byte.
REQ-010 SHALL have port out_ready  input  1  downstream accepts; transfer occurs when out_valid and out_ready are both high at a rising edge.

Function
REQ-011 SHALL hold a 2-entry output buffer (occupancy 0/1/2, states EMPTY/HALF/FULL) plus one in-flight flag for a read issued the previous cycle.
REQ-012 SHALL drive fifo_read_en = ~rst & drain_en & ~fifo_empty & (occupancy + inflight - pop < 2), where pop = out_valid & out_ready; combinational from out_ready.
REQ-013 SHALL capture fifo_data into the buffer tail at the edge ending the cycle after fifo_read_en was high.
REQ-014 SHALL assert out_valid whenever occupancy > 0; out_data SHALL be the buffer head.
REQ-015 SHALL keep out_data and out_valid stable while out_valid & ~out_ready.
REQ-016 SHALL deliver bytes in exact FIFO pop order, no drops, no duplicates.
REQ-017 Latency: fifo_read_en high in cycle N -> out_valid high in cycle N+2 (when buffer was empty).
REQ-018 Throughput: with out_ready held high and FIFO non-empty, one transfer per cycle, no bubbles after the first.
REQ-019 Simultaneous capture and pop SHALL leave occupancy unchanged; FULL->HALF on pop only; HALF->FULL on capture only; HALF->EMPTY on pop only; EMPTY->HALF on capture.
REQ-020 SHALL never issue fifo_read_en while fifo_empty is high.
REQ-021 drain_en low SHALL stop new reads only; buffered and in-flight bytes SHALL still be delivered.

Reset
REQ-022 On rst high at a rising edge: occupancy=0, inflight=0, out_valid=0, out_data=0, (out_count=0 when enabled).
REQ-023 fifo_read_en SHALL be 0 in every cycle rst is high.
REQ-024 Reset mid-operation SHALL discard buffered and in-flight bytes; none appear on out_data after reset.

Configuration
REQ-025 Macro FIFO_READER_COUNT_EN defined: SHALL add port out_count  output  16  number of completed transfers since reset, incremented on each transfer, saturating at 65535.
REQ-026 Macro FIFO_READER_COUNT_EN undefined: out_count port and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-027 Reset, FIFO preloaded with 0..9, out_ready=1, drain_en=1 -> out_data 0..9 on 10 consecutive cycles; first out_valid 2 cycles after first fifo_read_en.
REQ-028 FIFO non-empty, out_ready=0 for 6 cycles -> fifo_read_en high exactly 2 cycles, out_data holds 0; out_ready=1 -> 0,1,2,3 delivered back-to-back.
REQ-029 FIFO goes empty after 3 pops -> exactly 3 bytes delivered, out_valid drops, fifo_read_en stays 0 while fifo_empty high.
REQ-030 rst asserted with occupancy 2 and one read in flight -> next cycle out_valid=0, out_data=0, fifo_read_en=0; no stale byte appears after release.
REQ-031 drain_en dropped with occupancy 2 -> no further reads; the 2 buffered bytes still delivered in order.
REQ-032 With FIFO_READER_COUNT_EN: 70 transfers -> out_count=70; 65540 transfers -> out_count=65535.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Pulls bytes from a synchronous FIFO (one-cycle read latency) into a
// 2-entry skid buffer and presents them as a valid/ready stream. Reads are
// issued only when the buffer is guaranteed to have room for the returning
// byte, so a stalled consumer never causes a drop.
// Optional feature: define FIFO_READER_COUNT_EN to add the saturating
// 16-bit transfer counter on port out_count.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  drain_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
`ifdef FIFO_READER_COUNT_EN
    output logic [15:0]           out_count,
`endif
    input  logic                  out_ready
);

    // Encoding equals the number of buffered bytes, so the state doubles as
    // the occupancy count in the read-permission arithmetic.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } occ_e;

    occ_e                  r_state;
    occ_e                  w_state_nxt;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic                  w_pop;
    logic                  w_capture;
    logic                  w_wr_idx;
    logic [2:0]            w_level;

    // Handshake terms and read permission: a read is allowed only if the
    // byte it returns next cycle will find a free slot after this cycle's pop.
    always_comb begin
        w_pop        = (r_state != ST_EMPTY) & out_ready;
        w_capture    = r_inflight;
        w_level      = {1'b0, r_state} + {2'b00, r_inflight} - {2'b00, w_pop};
        fifo_read_en = ~rst & drain_en & ~fifo_empty & (w_level < 3'd2);
        // Tail slot after this cycle's pop: slot 1 if the head stays, else 0.
        w_wr_idx     = (r_state == ST_FULL) | ((r_state == ST_HALF) & ~w_pop);
    end

    // Next occupancy and stream valid from capture/pop combinations.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        out_valid   = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_capture) w_state_nxt = ST_HALF;
            end
            ST_HALF: begin
                out_valid = 1'b1;
                if (w_capture && !w_pop)      w_state_nxt = ST_FULL;
                else if (!w_capture && w_pop) w_state_nxt = ST_EMPTY;
            end
            ST_FULL: begin
                out_valid = 1'b1;
                if (w_pop && !w_capture) w_state_nxt = ST_HALF;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Occupancy state and in-flight read flag.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= fifo_read_en;
        end
    end

    // Buffer storage: shift on pop, write the returning byte into the tail.
    // NOTE: the two data slots are reset because out_data must read zero
    // after reset; a deeper store would normally be left unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            if (w_pop) r_buf0 <= r_buf1;
            if (w_capture) begin
                if (w_wr_idx) r_buf1 <= fifo_data;
                else          r_buf0 <= fifo_data;
            end
        end
    end

    assign out_data = r_buf0;

`ifdef FIFO_READER_COUNT_EN
    logic [15:0] r_count;

    // Saturating count of completed stream transfers since reset.
    always_ff @(posedge clk) begin
        if (rst)                          r_count <= '0;
        else if (w_pop && r_count != '1)  r_count <= r_count + 16'd1;
    end

    assign out_count = r_count;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
// Randomized and directed stimulus against a queue-based reference model of
// the reader. A bench-side FIFO model supplies data with one-cycle latency.
// Define FIFO_READER_COUNT_EN to also exercise the transfer counter.
module tb_fifo_stream_reader;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          drain_en = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_read_en;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
`ifdef FIFO_READER_COUNT_EN
    logic [15:0]   out_count;
`endif

    fifo_stream_reader #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .drain_en     (drain_en),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_read_en (fifo_read_en),
        .out_data     (out_data),
        .out_valid    (out_valid),
`ifdef FIFO_READER_COUNT_EN
        .out_count    (out_count),
`endif
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Bench FIFO contents and reference model of the reader.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] model_q[$];
    logic          model_inf = 1'b0;
    logic [DW-1:0] model_inf_val = '0;

    // Per-scenario statistics.
    logic [DW-1:0] delivered[$];
    int cyc = 0;
    int rd_cycles = 0;
    int n_xfer = 0;
    int first_rd = -1;
    int first_valid = -1;
    int first_xfer = -1;
    int last_xfer = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One clock cycle: compare at negedge, then advance model and FIFO #1
    // after the rising edge, where the next inputs are also applied.
    task automatic step();
        logic exp_pop;
        logic exp_read;
        logic act_read;
        int   occ;
        @(negedge clk);
        occ      = model_q.size();
        exp_pop  = (occ > 0) && out_ready;
        exp_read = !rst && drain_en && !fifo_empty &&
                   ((occ + int'(model_inf) - (exp_pop ? 1 : 0)) < 2);
        check("read_en", 32'(fifo_read_en), 32'(exp_read));
        check("valid", 32'(out_valid), 32'(occ > 0));
        if (occ > 0) check("data", 32'(out_data), 32'(model_q[0]));
        act_read = fifo_read_en && !fifo_empty;
        if (fifo_read_en) begin
            rd_cycles++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (!rst && out_valid && out_ready) begin
            delivered.push_back(out_data);
            n_xfer++;
            if (first_xfer < 0) first_xfer = cyc;
            last_xfer = cyc;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            model_q.delete();
            model_inf = 1'b0;
        end else begin
            if (exp_pop) void'(model_q.pop_front());
            if (model_inf) model_q.push_back(model_inf_val);
            model_inf = exp_read;
            if (exp_read) model_inf_val = fifo_q[0];
        end
        if (act_read) fifo_data = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
        cyc++;
    endtask

    task automatic clear_stats();
        delivered.delete();
        rd_cycles   = 0;
        n_xfer      = 0;
        first_rd    = -1;
        first_valid = -1;
        first_xfer  = -1;
        last_xfer   = -1;
    endtask

    task automatic do_reset();
        fifo_q.delete();
        fifo_empty = 1'b1;
        drain_en   = 1'b1;
        out_ready  = 1'b0;
        rst        = 1'b1;
        step();
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        step();
        rst = 1'b0;
        clear_stats();
    endtask

    task automatic load(input int n, input int base);
        for (int i = 0; i < n; i++) fifo_q.push_back(DW'(base + i));
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // First edge establishes the reset state before any comparison.
        @(posedge clk);
        #1;

        // Preloaded 0..9 streams out back-to-back with 2-cycle latency.
        do_reset();
        out_ready = 1'b1;
        load(10, 0);
        run(16);
        check("lat_first_valid", 32'(first_valid - first_rd), 32'd2);
        check("s1_xfers", 32'(n_xfer), 32'd10);
        check("s1_consecutive", 32'(last_xfer - first_xfer), 32'd9);
        for (int i = 0; i < 10 && i < delivered.size(); i++)
            check("s1_order", 32'(delivered[i]), 32'(i));

        // Consumer stalled: exactly two reads, head held, then 0..3 back-to-back.
        do_reset();
        load(8, 0);
        run(6);
        check("s2_reads_stalled", 32'(rd_cycles), 32'd2);
        check("s2_head_held", 32'(out_data), 32'd0);
        out_ready = 1'b1;
        run(4);
        check("s2_xfers", 32'(n_xfer), 32'd4);
        for (int i = 0; i < 4 && i < delivered.size(); i++)
            check("s2_order", 32'(delivered[i]), 32'(i));

        // FIFO runs dry after three entries.
        do_reset();
        out_ready = 1'b1;
        load(3, 8'hA0);
        run(8);
        check("s3_xfers", 32'(n_xfer), 32'd3);
        check("s3_reads", 32'(rd_cycles), 32'd3);
        check("s3_valid_low", 32'(out_valid), 32'd0);

        // Reset with bytes buffered and a read in flight.
        do_reset();
        load(8, 8'h10);
        run(3);
        out_ready = 1'b1;
        run(1);
        rst = 1'b1;
        out_ready = 1'b0;
        run(1);
        check("s4_valid_after_rst", 32'(out_valid), 32'd0);
        check("s4_data_after_rst", 32'(out_data), 32'd0);
        check("s4_read_in_rst", 32'(fifo_read_en), 32'd0);
        run(1);
        rst = 1'b0;
        out_ready = 1'b1;
        clear_stats();
        run(10);
        check("s4_xfers", 32'(n_xfer), 32'd5);
        if (delivered.size() > 0) check("s4_first_after_rst", 32'(delivered[0]), 32'h13);
        else check("s4_first_after_rst", 32'd0, 32'h13);

        // drain_en dropped while full: buffered bytes still drain in order.
        do_reset();
        load(6, 8'h40);
        run(3);
        drain_en = 1'b0;
        rd_cycles = 0;
        run(3);
        out_ready = 1'b1;
        run(5);
        check("s5_no_reads", 32'(rd_cycles), 32'd0);
        check("s5_xfers", 32'(n_xfer), 32'd2);
        if (delivered.size() == 2) begin
            check("s5_byte0", 32'(delivered[0]), 32'h40);
            check("s5_byte1", 32'(delivered[1]), 32'h41);
        end

        // Random traffic, occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drain_en  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 4) < 3);
            if ($urandom_range(0, 2) != 0) fifo_q.push_back(DW'($urandom));
            fifo_empty = (fifo_q.size() == 0);
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;

`ifdef FIFO_READER_COUNT_EN
        do_reset();
        check("cnt_reset", 32'(out_count), 32'd0);
        out_ready = 1'b1;
        load(70, 0);
        run(75);
        check("cnt_70", 32'(out_count), 32'd70);
        for (int i = 0; i < 70000 && n_xfer < 65540; i++) begin
            if (fifo_q.size() < 4) fifo_q.push_back(DW'(i));
            fifo_empty = (fifo_q.size() == 0);
            step();
        end
        check("cnt_xfer_budget", 32'(n_xfer), 32'd65540);
        check("cnt_saturated", 32'(out_count), 32'd65535);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
